nios_system_leds_out: RTL and testbench

Avalon-MM slave output port driving the board LEDs from the Nios II data bus. It is the write-direction counterpart of the switches input port. It holds an 8-bit output register and supports a toggle-write address. An optional hardware blink engine periodically blanks masked bits without CPU involvement.

---
 rtl/nios_system_leds_out_if.sv | 24 ++
 rtl/nios_system_leds_out.sv | 113 +++++++++++
 tb/tb_nios_system_leds_out.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/nios_system_leds_out_if.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_leds_out_if
// Brief    : Avalon-MM slave bus bundle for the LED output port.
// Revision : 1.0
// ============================================================================
interface nios_system_leds_out_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/nios_system_leds_out.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_leds_out
// Brief    : Avalon-MM LED output port with toggle-write and optional blink
//            engine (enabled by defining LEDS_OUT_BLINK_EN).
// Revision : 1.0
// ============================================================================
module nios_system_leds_out #(
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  nios_system_leds_out_if.slave  bus,
  output logic [7:0]             out_port
);

  localparam logic [1:0] c_addr_data   = 2'd0;
  localparam logic [1:0] c_addr_mask   = 2'd1;
  localparam logic [1:0] c_addr_period = 2'd2;
  localparam logic [1:0] c_addr_toggle = 2'd3;

  logic       w_write;
  logic [7:0] r_data;
  logic [7:0] w_mask;
  logic [15:0] w_period;
  logic       w_phase;

  assign w_write = bus.chipselect & ~bus.write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RESET_VALUE;
    end else if (w_write && bus.address == c_addr_data) begin
      r_data <= bus.writedata[7:0];
    end else if (w_write && bus.address == c_addr_toggle) begin
      r_data <= r_data ^ bus.writedata[7:0];
    end
  end

`ifdef LEDS_OUT_BLINK_EN
  logic [7:0]  r_mask;
  logic [15:0] r_period;
  logic [15:0] r_cnt;
  logic        r_phase;
  logic        w_unused;

  assign w_unused = ^bus.writedata[31:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= 8'h00;
    end else if (w_write && bus.address == c_addr_mask) begin
      r_mask <= bus.writedata[7:0];
    end
  end

  // A PERIOD write restarts the engine and takes priority over decrement/toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= 16'h0000;
      r_cnt    <= 16'h0000;
      r_phase  <= 1'b0;
    end else if (w_write && bus.address == c_addr_period) begin
      r_period <= bus.writedata[15:0];
      r_cnt    <= bus.writedata[15:0];
      r_phase  <= 1'b0;
    end else if (r_period == 16'h0000) begin
      r_cnt    <= 16'h0000;
      r_phase  <= 1'b0;
    end else if (r_cnt == 16'h0000) begin
      r_cnt    <= r_period;
      r_phase  <= ~r_phase;
    end else begin
      r_cnt    <= r_cnt - 16'h0001;
    end
  end

  assign w_mask   = r_mask;
  assign w_period = r_period;
  assign w_phase  = r_phase;
`else
  logic w_unused;

  assign w_unused = ^bus.writedata[31:8];
  assign w_mask   = 8'h00;
  assign w_period = 16'h0000;
  assign w_phase  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else begin
      out_port <= r_data & ~(w_mask & {8{w_phase}});
    end
  end

  // Read path is free-running: it ignores chipselect and returns pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= 32'h0000_0000;
    end else begin
      case (bus.address)
        c_addr_data:   bus.readdata <= {24'h000000, r_data};
        c_addr_mask:   bus.readdata <= {24'h000000, w_mask};
        c_addr_period: bus.readdata <= {16'h0000, w_period};
        default:       bus.readdata <= {31'h00000000, w_phase};
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_system_leds_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_system_leds_out
// Brief    : Directed self-checking bench for nios_system_leds_out.
// Revision : 1.0
// ============================================================================
module tb_nios_system_leds_out;

  logic       clk;
  logic       reset_n;
  logic [7:0] out_port;
  int         checks;
  int         errors;
  logic [7:0] exp_data;

  nios_system_leds_out_if bus ();

  nios_system_leds_out #(.RESET_VALUE(8'hA5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    check(tag, bus.readdata, exp);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    reset_n        = 1'b1;
    #2 reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_port", {24'h0, out_port}, 32'h0000_00A5);
    check("reset_readdata", bus.readdata, 32'h0);
    reset_n = 1'b1;

    bus_read(2'd0, 32'h0000_00A5, "read_data_reset");

    bus_write(2'd0, 32'hFFFF_FF3C);
    bus_write(2'd3, 32'h0000_000F);
    check("out_before_toggle", {24'h0, out_port}, 32'h0000_003C);
    @(negedge clk);
    check("out_after_toggle", {24'h0, out_port}, 32'h0000_0033);
    bus_read(2'd0, 32'h0000_0033, "read_data_toggled");
    exp_data = 8'h33;

`ifdef LEDS_OUT_BLINK_EN
    bus_write(2'd0, 32'h0000_00FF);
    bus_write(2'd1, 32'h0000_000F);
    bus_write(2'd2, 32'h0000_0003);
    bus.address = 2'd3;
    // Phase flips every 4 cycles; out_port lags phase by one edge.
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("blink3_out_%0d", k), {24'h0, out_port},
            ((((k - 1) / 4) % 2) == 1) ? 32'h0000_00F0 : 32'h0000_00FF);
      check($sformatf("blink3_phase_%0d", k), bus.readdata,
            32'(((k - 1) / 4) % 2));
    end
    bus_write(2'd2, 32'h0000_0005);
    check("period_old_on_write", bus.readdata, 32'h0000_0003);
    check("out_at_restart_edge", {24'h0, out_port}, 32'h0000_00F0);
    bus.address = 2'd3;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("blink5_out_%0d", k), {24'h0, out_port},
            (k >= 7) ? 32'h0000_00F0 : 32'h0000_00FF);
      check($sformatf("blink5_phase_%0d", k), bus.readdata,
            (k >= 7) ? 32'h1 : 32'h0);
    end
    bus_read(2'd1, 32'h0000_000F, "read_mask");
    bus_read(2'd2, 32'h0000_0005, "read_period");
    bus_write(2'd2, 32'h0000_0000);
    @(negedge clk);
    check("out_blink_stopped", {24'h0, out_port}, 32'h0000_00FF);
    exp_data = 8'hFF;
`else
    bus_write(2'd1, 32'h0000_00FF);
    bus_write(2'd2, 32'h0000_0001);
    bus_read(2'd1, 32'h0, "noblink_read_mask");
    bus_read(2'd2, 32'h0, "noblink_read_period");
    bus_read(2'd3, 32'h0, "noblink_read_status");
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("noblink_out_%0d", k), {24'h0, out_port}, 32'h0000_0033);
    end
`endif

    // Write with chipselect low must be ignored.
    @(negedge clk);
    bus.address    = 2'd0;
    bus.writedata  = 32'h0000_0000;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.write_n    = 1'b1;
    bus_read(2'd0, {24'h0, exp_data}, "cs_low_write_ignored");
    check("cs_low_out_port", {24'h0, out_port}, {24'h0, exp_data});

    // Asynchronous reset between edges.
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_out", {24'h0, out_port}, 32'h0000_00A5);
    check("async_reset_readdata", bus.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd1, 32'h0, "post_reset_mask");
    bus_read(2'd3, 32'h0, "post_reset_phase");
    bus_read(2'd0, 32'h0000_00A5, "post_reset_data");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
